// File: rtl/control_sequencer.sv
// control_sequencer: microcoded control unit for the 8-bit bus computer.
// Ports: clk (falling edge steps the microcounter), clr_ (async active-low reset),
//   prog (0 = idle/programming, 1 = run), op (IR opcode), cf/zf (latched flags),
//   hlt..fi (16 active-high control lines), step (current microstep), halted (sticky halt).
module control_sequencer #(
  parameter int OPW     = 4,
  parameter int SW      = 3,
  parameter int MAXSTEP = 4
) (
  input  logic           clk,
  input  logic           clr_,
  input  logic           prog,
  input  logic [OPW-1:0] op,
  input  logic           cf,
  input  logic           zf,
  output logic           hlt,
  output logic           mi,
  output logic           ri,
  output logic           ro,
  output logic           io,
  output logic           ii,
  output logic           ai,
  output logic           ao,
  output logic           eo,
  output logic           su,
  output logic           bi,
  output logic           oi,
  output logic           ce,
  output logic           co,
  output logic           j,
  output logic           fi,
  output logic [SW-1:0]  step,
  output logic           halted
);
  localparam logic [15:0] C_HLT = 16'h8000, C_MI = 16'h4000, C_RI = 16'h2000, C_RO = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800, C_II = 16'h0400, C_AI = 16'h0200, C_AO = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080, C_SU = 16'h0040, C_BI = 16'h0020, C_OI = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008, C_CO = 16'h0004, C_J  = 16'h0002, C_FI = 16'h0001;

  logic [SW-1:0] step_q, step_d, step_nx;
  logic          halted_q, halted_d;
  logic [15:0]   ctl;

  function automatic logic [15:0] ucode(input logic [SW-1:0] s, input logic [OPW-1:0] o,
                                        input logic c, input logic z);
    logic [15:0] w;
    w = '0;
    case (int'(s))
      0: w = C_CO | C_MI;
      1: w = C_RO | C_II | C_CE;
      2: case (int'(o))
           1, 2, 3, 4: w = C_IO | C_MI;
           5:          w = C_IO | C_AI;
           6:          w = C_IO | C_J;
           7:          w = c ? (C_IO | C_J) : '0;
           8:          w = z ? (C_IO | C_J) : '0;
           14:         w = C_AO | C_OI;
           15:         w = C_HLT;
           default:    w = '0;
         endcase
      3: case (int'(o))
           1:       w = C_RO | C_AI;
           2, 3:    w = C_RO | C_BI;
           4:       w = C_AO | C_RI;
           default: w = '0;
         endcase
      4: case (int'(o))
           2:       w = C_EO | C_AI | C_FI;
           3:       w = C_EO | C_AI | C_SU | C_FI;
           default: w = '0;
         endcase
      default: w = '0;
    endcase
    return w;
  endfunction

  // An instruction ends early when the next microword would be empty, so
  // short opcodes (and untaken jumps) do not waste idle cycles.
  always_comb begin
    step_nx  = step_q + SW'(1);
    ctl      = !prog ? '0 : halted_q ? C_HLT : ucode(step_q, op, cf, zf);
    step_d   = halted_q ? step_q :
               !prog ? '0 :
               ctl[15] ? step_q :
               (int'(step_q) >= MAXSTEP || ucode(step_nx, op, cf, zf) == '0) ? '0 : step_nx;
    halted_d = halted_q | (prog & ctl[15]);
  end

  // Stepping on the falling edge keeps control lines settled for the rising-edge datapath.
  always_ff @(negedge clk or negedge clr_) begin
    if (!clr_) begin
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  assign {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi} = ctl;
  assign step   = step_q;
  assign halted = halted_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and randomized checks of control_sequencer against a microcode-table model.
module tb_control_sequencer;
  localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
  localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
  localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
  localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002, FI = 16'h0001;

  typedef logic [15:0] wq_t[$];

  logic clk = 1'b0, clr_, prog, cf, zf;
  logic [3:0] op;
  logic hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi, halted;
  logic [2:0] step;
  logic [15:0] word;
  int checks = 0, errors = 0;
  int m_step;
  bit m_halt;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .clr_(clr_), .prog(prog), .op(op), .cf(cf), .zf(zf),
    .hlt(hlt), .mi(mi), .ri(ri), .ro(ro), .io(io), .ii(ii), .ai(ai), .ao(ao),
    .eo(eo), .su(su), .bi(bi), .oi(oi), .ce(ce), .co(co), .j(j), .fi(fi),
    .step(step), .halted(halted)
  );

  assign word = {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi};

  // Whole instruction as a list of microwords; its length is the instruction length.
  function automatic wq_t ucode(input logic [3:0] o, input logic c, input logic z);
    wq_t w;
    w = '{CO | MI, RO | II | CE};
    case (o)
      4'd1:  begin w.push_back(IO | MI); w.push_back(RO | AI); end
      4'd2:  begin w.push_back(IO | MI); w.push_back(RO | BI); w.push_back(EO | AI | FI); end
      4'd3:  begin w.push_back(IO | MI); w.push_back(RO | BI); w.push_back(EO | AI | SU | FI); end
      4'd4:  begin w.push_back(IO | MI); w.push_back(AO | RI); end
      4'd5:  w.push_back(IO | AI);
      4'd6:  w.push_back(IO | J);
      4'd7:  if (c) w.push_back(IO | J);
      4'd8:  if (z) w.push_back(IO | J);
      4'd14: w.push_back(AO | OI);
      4'd15: w.push_back(HLT);
      default: ;
    endcase
    return w;
  endfunction

  function automatic logic [15:0] mexp();
    wq_t q;
    q = ucode(op, cf, zf);
    if (!prog) return '0;
    if (m_halt) return HLT;
    return (m_step < q.size()) ? q[m_step] : 16'h0;
  endfunction

  task automatic madv();
    wq_t q;
    q = ucode(op, cf, zf);
    if (!clr_ || m_halt) return;
    if (!prog) m_step = 0;
    else if (mexp() & HLT) m_halt = 1;
    else m_step = (m_step + 1 >= q.size()) ? 0 : m_step + 1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic mcheck(input string tag);
    chk({tag, "_word"}, word, mexp());
    chk({tag, "_step"}, 16'(step), 16'(m_step));
    chk({tag, "_halted"}, 16'(halted), 16'(m_halt));
  endtask

  task automatic tick();
    @(negedge clk);
    madv();
    #1;
  endtask

  task automatic pulse_reset();
    clr_ = 1'b0;
    #1;
    m_step = 0;
    m_halt = 0;
    mcheck("rst");
    clr_ = 1'b1;
    #1;
  endtask

  task automatic to_t0();
    for (int i = 0; i < 6 && m_step != 0; i++) tick();
    chk("to_t0", 16'(step), 16'h0);
  endtask

  initial begin
    int lda_s[5] = '{1, 2, 3, 0, 1};
    int sub_s[5] = '{1, 2, 3, 4, 0};
    clr_ = 1'b0; prog = 1'b0; op = 4'd0; cf = 1'b0; zf = 1'b0;
    m_step = 0; m_halt = 0;
    #2;
    mcheck("reset");
    chk("reset_step", 16'(step), 16'h0);
    clr_ = 1'b1;
    repeat (3) begin
      tick();
      mcheck("idle");
      chk("idle_word", word, 16'h0);
    end
    prog = 1'b1;
    #1;
    chk("t0_word", word, CO | MI);
    // LDA
    op = 4'd1;
    #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      mcheck("lda");
      chk("lda_step", 16'(step), 16'(lda_s[i]));
      if (i == 1) chk("lda_t2", word, IO | MI);
      if (i == 2) chk("lda_t3", word, RO | AI);
    end
    to_t0();
    // SUB
    op = 4'd3;
    #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      mcheck("sub");
      chk("sub_step", 16'(step), 16'(sub_s[i]));
      if (i == 3) chk("sub_t4", word, EO | AI | SU | FI);
    end
    // Conditional jumps, not taken then taken
    for (int k = 0; k < 4; k++) begin
      to_t0();
      op = (k < 2) ? 4'd7 : 4'd8;
      cf = (k == 1);
      zf = (k == 3);
      #1;
      tick();
      mcheck("jmp_t1");
      chk("jmp_t1_step", 16'(step), 16'h1);
      chk("jmp_t1_j", 16'(j), 16'h0);
      tick();
      mcheck("jmp_t2");
      if (k == 1 || k == 3) begin
        chk("jmp_taken_step", 16'(step), 16'h2);
        chk("jmp_taken_word", word, IO | J);
        tick();
        mcheck("jmp_after");
      end
      chk("jmp_end_step", 16'(step), 16'h0);
    end
    cf = 1'b0; zf = 1'b0;
    // HLT
    to_t0();
    op = 4'd15;
    #1;
    tick();
    tick();
    chk("hlt_t2", word, HLT);
    tick();
    chk("hlt_halted", 16'(halted), 16'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      mcheck("halt_hold");
      chk("halt_step", 16'(step), 16'h2);
    end
    prog = 1'b0;
    tick();
    mcheck("halt_prog0");
    chk("halt_prog0_step", 16'(step), 16'h2);
    prog = 1'b1;
    tick();
    chk("halt_prog1_word", word, HLT);
    chk("halt_prog1_halted", 16'(halted), 16'h1);
    pulse_reset();
    chk("halt_clr_step", 16'(step), 16'h0);
    chk("halt_clr_halted", 16'(halted), 16'h0);
    // Reset mid-instruction during T3 of ADD
    op = 4'd2;
    #1;
    tick(); tick(); tick();
    chk("add_t3_step", 16'(step), 16'h3);
    @(posedge clk);
    #1;
    pulse_reset();
    chk("midrst_step", 16'(step), 16'h0);
    chk("midrst_t0", word, CO | MI);
    tick();
    mcheck("midrst_next");
    // Randomized run
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2 || (m_halt && r < 30)) pulse_reset();
      if ($urandom_range(0, 9) < 3) op = 4'($urandom_range(0, 15));
      cf = 1'($urandom);
      zf = 1'($urandom);
      prog = (r >= 8);
      #1;
      mcheck("rnd_comb");
      tick();
      mcheck("rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Microcoded control unit for the 8-bit bus computer. It holds a step counter and decodes the IR opcode, the step and the latched flags into the 16 active-high control lines that drive the registers, ALU/flags, MAR, RAM, PC and output register. The step counter advances on the falling edge of clk so that control lines are stable before every rising-edge datapath latch.

Parameters:
OPW, 4, opcode width (IR upper nibble)
SW, 3, step counter width
MAXSTEP, 4, last legal step index (T0..T4)

Ports:
clk  input  1  system clock; datapath latches on rising edge, this block steps on falling edge
clr_  input  1  asynchronous active-low reset
prog  input  1  0 = manual programming (sequencer idle), 1 = run
op  input  OPW  opcode, IR[7:4]
cf  input  1  latched carry flag
zf  input  1  latched zero flag
hlt mi ri ro io ii ai ao eo su bi oi ce co j fi  output  1 each  control lines, active high
step  output  SW  current microstep
halted  output  1  sticky halt status

Behaviour:
- Reset (clr_=0, asynchronous, any time including mid-instruction): step=0, halted=0. Outputs then decode T0 when prog=1, or all zero when prog=0.
- prog=0: all 16 control outputs are 0. Step is held at 0 on every falling edge. halted is unchanged.
- Control outputs are combinational from (step, op, cf, zf, halted, prog). They are glitch-tolerant because step changes only on the falling edge.
- Fetch, common to all opcodes:
  - T0: co mi.
  - T1: ro ii ce.
- Execute (T2, T3, T4; any line not listed is 0):
  - 0000 NOP: none.
  - 0001 LDA: T2 io mi; T3 ro ai.
  - 0010 ADD: T2 io mi; T3 ro bi; T4 eo ai fi.
  - 0011 SUB: T2 io mi; T3 ro bi; T4 eo ai su fi.
  - 0100 STA: T2 io mi; T3 ao ri.
  - 0101 LDI: T2 io ai.
  - 0110 JMP: T2 io j.
  - 0111 JC: T2 io j only if cf=1, otherwise T2 word is zero.
  - 1000 JZ: T2 io j only if zf=1, otherwise T2 word is zero.
  - 1110 OUT: T2 ao oi.
  - 1111 HLT: T2 hlt.
  - 1001-1101: treated as NOP.
- Step advance (falling edge, prog=1, halted=0):
  - step <= 0 if step==MAXSTEP or the decoded word for step+1 (same op, current flags) is all zero.
  - Otherwise step <= step+1.
  - Resulting instruction lengths in cycles: NOP=2, LDI=3, JMP=3, JC/JZ taken=3, JC/JZ not taken=2, LDA=4, STA=4, ADD=5, SUB=5.
- Halt:
  - On a falling edge with hlt=1, halted <= 1 and step is frozen.
  - While halted: hlt=1, all other lines 0, step constant.
  - Only clr_ clears halted; prog toggling does not.
- Flag sampling: cf/zf are read combinationally during T2 of JC/JZ. A flag change at the rising edge of T2 (fi is never active in T2) cannot occur by construction.
- Wrap-around: step never exceeds MAXSTEP. Step values 5-7 are unreachable; if forced, they decode to all-zero outputs and return to 0 at the next falling edge.
- Simultaneous events: clr_ assertion overrides any falling-edge update. prog falling to 0 mid-instruction forces step to 0 on the next falling edge, aborting the instruction.

Test Plan:
- Reset/idle: clr_=0 then 1, prog=0, 3 clocks -> step=0, all lines 0, halted=0. Set prog=1 -> co=mi=1 immediately.
- LDA: op=0001, prog=1, run 5 falling edges -> step sequence 0,1,2,3,0. Words seen: {co,mi}, {ro,ii,ce}, {io,mi}, {ro,ai}.
- SUB: op=0011 -> steps 0..4 then 0. T4 has eo=ai=su=fi=1 and no other line set.
- Conditional jump: op=0111 with cf=0 -> steps 0,1,0, j never 1. Repeat with cf=1 -> steps 0,1,2,0, with io=j=1 at T2. Same pair for JZ with zf.
- HLT: op=1111 -> at T2 hlt=1. After the next falling edge halted=1 and step stays 2 for 10 clocks. Toggling prog has no effect. clr_ pulse low -> step=0, halted=0.
- Reset mid-instruction: op=0010, assert clr_=0 between falling edges during T3 -> step=0 at once, asynchronously. After release, the next cycle shows the T0 word.
